// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//
// Receive-side counterpart of the 480p60 VGA output stage. It sits after the
// pin registers in the clk_pix domain. It locks to the incoming hsync/vsync
// timing, recovers the x/y coordinate of every sample and checks the sync
// edges against the raster parameters. It also flags colour that is driven
// during blanking.
//
// Ports:
//   clk_pix                 pixel clock
//   resetn                  synchronous active-low reset
//   vga_r/vga_g/vga_b       sampled 4-bit colour
//   vga_hsync/vga_vsync     sampled sync levels (asserted level = SYNC_POL)
//   x, y                    recovered coordinate of the output pixel
//   active                  output pixel is visible and the receiver is not searching
//   r, g, b                 captured colour, forced to 0 when active=0
//   frame_start             one-cycle pulse at x=0, y=0 while locked
//   locked                  sync timing verified for a whole frame
//   h_err, v_err, blank_err one-cycle error pulses
//   err_count               saturating count of cycles with h_err or v_err
//
// Latency: the sample taken at cycle n is reported at cycle n+1, together
// with its coordinate, its error pulses and the resulting state.

module vga_sync_receiver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk_pix,
  input  logic        resetn,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err,
  output logic [15:0] err_count
);

  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] H_TOTAL_M1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_TOTAL_M1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        active_q, active_d;
  logic [3:0]  r_q, r_d;
  logic [3:0]  g_q, g_d;
  logic [3:0]  b_q, b_d;
  logic        frame_start_q, frame_start_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;
  logic        blank_err_q, blank_err_d;
  logic [15:0] err_count_q, err_count_d;

  logic [9:0]  h_pred;
  logic [9:0]  v_pred;
  logic        hs_assert, hs_deassert;
  logic        vs_assert, vs_deassert;
  logic        checking;
  logic        visible;
  logic        any_err;

  // Prediction, edge checks, resync, state machine and output staging.
  always_comb begin
    h_pred        = (hcnt_q == H_TOTAL_M1) ? 10'd0 : hcnt_q + 10'd1;
    v_pred        = vcnt_q;
    if (h_pred == 10'd0) begin
      v_pred = (vcnt_q == V_TOTAL_M1) ? 10'd0 : vcnt_q + 10'd1;
    end

    hs_assert     = (vga_hsync != hs_prev_q) && (vga_hsync == SYNC_POL);
    hs_deassert   = (vga_hsync != hs_prev_q) && (vga_hsync != SYNC_POL);
    vs_assert     = (vga_vsync != vs_prev_q) && (vga_vsync == SYNC_POL);
    vs_deassert   = (vga_vsync != vs_prev_q) && (vga_vsync != SYNC_POL);

    // Timing is only judged once a vsync assert has aligned the counters.
    checking      = (state_q != ST_SEARCH);

    h_err_d       = checking &&
                    ((hs_assert   && (h_pred != HS_START)) ||
                     (hs_deassert && (h_pred != HS_END)));
    v_err_d       = checking &&
                    ((vs_assert   && !((h_pred == 10'd0) && (v_pred == VS_START))) ||
                     (vs_deassert && !((h_pred == 10'd0) && (v_pred == VS_END))));
    any_err       = h_err_d || v_err_d;

    // Sync edges realign the counters in every state; vsync wins if both fire.
    hcnt_d        = h_pred;
    vcnt_d        = v_pred;
    if (hs_assert) begin
      hcnt_d = HS_START;
    end
    if (vs_assert) begin
      hcnt_d = 10'd0;
      vcnt_d = VS_START;
    end

    state_d       = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_assert) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (any_err)        state_d = ST_SEARCH;
        else if (vs_assert) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (any_err) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase

    visible       = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    active_d      = visible && (state_d != ST_SEARCH);
    x_d           = hcnt_d;
    y_d           = vcnt_d;
    r_d           = active_d ? vga_r : 4'd0;
    g_d           = active_d ? vga_g : 4'd0;
    b_d           = active_d ? vga_b : 4'd0;
    frame_start_d = (hcnt_d == 10'd0) && (vcnt_d == 10'd0) && (state_d == ST_LOCKED);
    blank_err_d   = checking && !visible && ((vga_r | vga_g | vga_b) != 4'd0);

    // A cycle with both h_err and v_err still counts as a single event.
    err_count_d   = err_count_q;
    if (any_err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end

    hs_prev_d     = vga_hsync;
    vs_prev_d     = vga_vsync;
  end

  // Sync history resets to the asserted level so a sync held through reset
  // is not mistaken for a fresh assert edge.
  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      state_q       <= ST_SEARCH;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hs_prev_q     <= SYNC_POL;
      vs_prev_q     <= SYNC_POL;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      blank_err_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_start_q <= frame_start_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      blank_err_q   <= blank_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == ST_LOCKED);
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign blank_err   = blank_err_q;
  assign err_count   = err_count_q;

endmodule
